rem5_tx: RTL and testbench
==========================

REM5_TX -- requirements
Module: rem5_tx

Interface
REQ-001 Parameter WIDTH, default 8, is the number of data bits per frame; legal values are 2..32.
REQ-002 Parameter PAD_BITS, default 3, is the number of check bits per frame; it is fixed at 3.
REQ-003 clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  is the synchronous, active-low reset (0 = reset).
REQ-005 in_valid  input  1  SHALL mean the source offers in_data.
REQ-006 in_ready  output  1  SHALL mean the block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  is the frame payload, sent MSB first.
REQ-008 x  output  1  is the serial bit stream, in the format consumed by the rem5 divisibility detector.
REQ-009 x_valid  output  1  SHALL mean x carries a frame bit this cycle.
REQ-010 sof / eof  output  1 each  SHALL mark the first and last bit of a frame.
REQ-011 rem  output  3  is the running mod-5 remainder of the bits already emitted.
REQ-012 busy  output  1  SHALL be high whenever the block is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and PAD.
REQ-014 The transfer SHALL complete when in_valid and in_ready are both high; in_ready SHALL be 1 only in IDLE.
REQ-015 On transfer: latch in_data, clear the bit counter, clear rem to 0 and go to SHIFT; x_valid SHALL rise in the next cycle.
REQ-016 SHIFT SHALL drive in_data[WIDTH-1-k] on x in its k-th cycle (k = 0..WIDTH-1), with x_valid = 1.
REQ-017 sof SHALL be 1 only at k = 0.
REQ-018 Each emitted bit b SHALL update rem at the clock edge ending its cycle: rem <= (2*rem + b) mod 5; rem SHALL never exceed 4.
REQ-019 After the last SHIFT cycle the block SHALL compute pad p = (-8*rem) mod 5, using the lookup rem 0,1,2,3,4 -> p 0,2,4,1,3, and go to PAD.
REQ-020 PAD SHALL emit the 3 bits of p MSB first with x_valid = 1; eof SHALL be 1 on the third pad bit.
REQ-021 The completed frame value, data*8 + p, SHALL be divisible by 5, so rem SHALL equal 0 after the final pad bit.
REQ-022 After the last PAD cycle the FSM SHALL return to IDLE.
REQ-023 Frame length SHALL be WIDTH+3 cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle, in which in_ready = 1.
REQ-024 Outside SHIFT and PAD: x = 0, x_valid = 0, sof = 0, eof = 0, and rem holds its last value.
REQ-025 in_valid and in_data SHALL be ignored while busy; in_data changing mid-frame SHALL NOT affect x.

Reset
REQ-026 When rst = 0 at a clock edge: state = IDLE, x = 0, x_valid = 0, sof = 0, eof = 0, rem = 0, busy = 0, in_ready = 1 from the next cycle.
REQ-027 Reset mid-frame SHALL abort the frame with no further x_valid; the next frame SHALL start clean.

Structure
REQ-028 Shared package rem5_pkg SHALL hold the FSM state enum, the PAD_BITS constant, the pad lookup table and the remainder-step function.
REQ-029 Sub-module rem5_acc SHALL be the registered mod-5 accumulator, with clear and enable inputs and rem output; it is shareable with the receiver.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 WIDTH=8, in_data=0x07 -> x = 00000111 then 100; eof on bit 11; final rem = 0 (value 60).
REQ-032 in_data=0x0D -> pad 001 (value 105); in_data=0x00 -> pad 000; in_data=0xFF -> pad 000.
REQ-033 Hold in_valid high with two words -> two 11-bit frames, one IDLE gap between them, in_ready high only in the gap.
REQ-034 Assert rst = 0 at SHIFT bit 4 -> x_valid = 0 the next cycle; then send 0x07 -> the frame matches REQ-031 exactly.
REQ-035 Loop x into rem5 with all 256 values -> rem5 out = 1 on every eof cycle; the scoreboard SHALL check x against data*8+p.

Source files
------------

// File: rtl/rem5_pkg.sv
// Shared definitions for the rem5 serial transmitter and its mod-5 accumulator.
package rem5_pkg;

    localparam int PAD_BITS = 3;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    // One serial step of the remainder: (2*r + b) mod 5, with r already in 0..4.
    function automatic logic [2:0] rem_step(input logic [2:0] r, input logic b);
        logic [3:0] t;
        t = {r, 1'b0} + {3'd0, b};
        if (t >= 4'd5) begin
            t = t - 4'd5;
        end else begin
            t = t;
        end
        return t[2:0];
    endfunction

    function automatic logic [2:0] pad_lut(input logic [2:0] r);
        logic [2:0] p;
        case (r)
            3'd0:    p = 3'd0;
            3'd1:    p = 3'd2;
            3'd2:    p = 3'd4;
            3'd3:    p = 3'd1;
            3'd4:    p = 3'd3;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rem5_acc.sv
// Registered mod-5 accumulator over an MSB-first bit stream; also usable on the receive side.
module rem5_acc
    import rem5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       b,
    output logic [2:0] rem
);

    logic [2:0] rem_r;

    // Remainder register: clear wins over a bit update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_r <= 3'd0;
        end else if (clr) begin
            rem_r <= 3'd0;
        end else if (en) begin
            rem_r <= rem_step(rem_r, b);
        end else begin
            rem_r <= rem_r;
        end
    end

    assign rem = rem_r;

endmodule

// File: rtl/rem5_tx.sv
// Serialises a WIDTH-bit word MSB first, then appends 3 pad bits making the frame divisible by 5.
module rem5_tx #(
    parameter int WIDTH    = 8,
    parameter int PAD_BITS = rem5_pkg::PAD_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic [2:0]       rem,
    output logic             busy
);
    import rem5_pkg::*;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PAD_LAST   = CNT_W'(PAD_BITS - 1);
    localparam logic [CNT_W-1:0] PAD_EOF    = CNT_W'(PAD_BITS - 2);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [WIDTH-1:0]  sh_r, sh_s;
    logic [2:0]        pad_r, pad_s;
    logic              x_r, x_s;
    logic              x_valid_r, x_valid_s;
    logic              sof_r, sof_s;
    logic              eof_r, eof_s;
    logic              in_ready_r, in_ready_s;
    logic              busy_r, busy_s;
    logic              take_s;
    logic [2:0]        pad_first_s;

    assign take_s = in_valid & in_ready_r;
    // The last data bit is still on x, so fold it in before looking up the pad.
    assign pad_first_s = pad_lut(rem_step(rem, x_r));

    rem5_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (take_s),
        .en  (x_valid_r),
        .b   (x_r),
        .rem (rem)
    );

    // Next-state and next-output logic; outputs describe the bit to present next cycle.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sh_s      = sh_r;
        pad_s     = pad_r;
        x_s       = 1'b0;
        x_valid_s = 1'b0;
        sof_s     = 1'b0;
        eof_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_s   = ST_SHIFT;
                    cnt_s     = '0;
                    sh_s      = {in_data[WIDTH-2:0], 1'b0};
                    x_s       = in_data[WIDTH-1];
                    x_valid_s = 1'b1;
                    sof_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                x_valid_s = 1'b1;
                if (cnt_r == SHIFT_LAST) begin
                    state_s = ST_PAD;
                    cnt_s   = '0;
                    pad_s   = {pad_first_s[1:0], 1'b0};
                    x_s     = pad_first_s[2];
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    sh_s  = {sh_r[WIDTH-2:0], 1'b0};
                    x_s   = sh_r[WIDTH-1];
                end
            end
            ST_PAD: begin
                if (cnt_r == PAD_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                    x_valid_s = 1'b1;
                    x_s       = pad_r[2];
                    pad_s     = {pad_r[1:0], 1'b0};
                    eof_s     = (cnt_r == PAD_EOF);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        in_ready_s = (state_s == ST_IDLE);
        busy_s     = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            sh_r       <= '0;
            pad_r      <= 3'd0;
            x_r        <= 1'b0;
            x_valid_r  <= 1'b0;
            sof_r      <= 1'b0;
            eof_r      <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sh_r       <= sh_s;
            pad_r      <= pad_s;
            x_r        <= x_s;
            x_valid_r  <= x_valid_s;
            sof_r      <= sof_s;
            eof_r      <= eof_s;
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
        end
    end

    assign x        = x_r;
    assign x_valid  = x_valid_r;
    assign sof      = sof_r;
    assign eof      = eof_r;
    assign in_ready = in_ready_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_rem5_tx.sv
// Scoreboard bench for rem5_tx: driver pushes expected frame bits, monitor pops them on x_valid.
module tb_rem5_tx;

    localparam int W = 8;
    localparam int L = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         x;
    logic         x_valid;
    logic         sof;
    logic         eof;
    logic [2:0]   rem;
    logic         busy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit xb;
        bit s;
        bit e;
        int r;
        int c;
    } exp_t;

    exp_t q[$];

    rem5_tx #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .x        (x),
        .x_valid  (x_valid),
        .sof      (sof),
        .eof      (eof),
        .rem      (rem),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the smallest pad 0..4 making data*8+pad a multiple of 5.
    function automatic longint frame_of(input int d);
        int p;
        p = (5 - ((d * 8) % 5)) % 5;
        return longint'(d) * 8 + longint'(p);
    endfunction

    // Expected bits of a frame accepted in cycle c: bit k appears in cycle c+1+k.
    task automatic push_frame(input longint v, input int c);
        exp_t e;
        for (int k = 0; k < L; k++) begin
            e.xb = bit'((v >> (L - 1 - k)) & 64'd1);
            e.s  = (k == 0);
            e.e  = (k == L - 1);
            e.r  = int'((v >> (L - k)) % 64'd5);
            e.c  = c + 1 + k;
            q.push_back(e);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        int det;
        det = 0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (x_valid === 1'b1) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bit cyc=%0d got x=%0b sof=%0b eof=%0b, want no frame bit", cyc, x, sof, eof);
                    end else begin
                        e = q.pop_front();
                        if (x !== e.xb || sof !== e.s || eof !== e.e || rem !== 3'(e.r) || cyc != e.c) begin
                            errors++;
                            $display("FAIL frame_bit cyc=%0d got x=%0b sof=%0b eof=%0b rem=%0d, want x=%0b sof=%0b eof=%0b rem=%0d cyc=%0d",
                                     cyc, x, sof, eof, rem, e.xb, e.s, e.e, e.r, e.c);
                        end
                    end
                    if (sof === 1'b1) det = 0;
                    det = (det * 2 + int'(x === 1'b1)) % 5;
                    if (eof === 1'b1) begin
                        checks++;
                        if (det != 0) begin
                            errors++;
                            $display("FAIL divisible_at_eof cyc=%0d got remainder=%0d, want 0", cyc, det);
                        end
                    end
                end else begin
                    checks++;
                    if (x !== 1'b0 || x_valid !== 1'b0 || sof !== 1'b0 || eof !== 1'b0 || rem !== 3'd0) begin
                        errors++;
                        $display("FAIL idle_outputs cyc=%0d got x=%0b x_valid=%0b sof=%0b eof=%0b rem=%0d, want all 0",
                                 cyc, x, x_valid, sof, eof, rem);
                    end
                end
                checks++;
                if (in_ready !== !busy || (in_ready === 1'b1 && x_valid === 1'b1)) begin
                    errors++;
                    $display("FAIL handshake cyc=%0d got in_ready=%0b busy=%0b x_valid=%0b, want in_ready=!busy and not with x_valid",
                             cyc, in_ready, busy, x_valid);
                end
                if (rst === 1'b0) q.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input logic [W-1:0] d, input longint v);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready === 1'b1) begin
                push_frame(v, cyc);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout data=%0h got no in_ready, want acceptance within 50 cycles", d);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (q.size() == 0 && busy === 1'b0) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%0b, want empty and idle", q.size(), busy);
            q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d, want bench to finish", cyc);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [W-1:0] words [2];
        int           acc_c [2];
        int           wi;
        int           idx;
        bit           found;
        bit           v;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0 || x !== 1'b0 || rem !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got in_ready=%0b busy=%0b x_valid=%0b x=%0b rem=%0d, want 1 0 0 0 0",
                     in_ready, busy, x_valid, x, rem);
        end
        rst = 1'b1;
        tick();

        send_lit(8'h07, 64'd60);
        wait_idle();
        send_lit(8'h0D, 64'd105);
        wait_idle();
        send_lit(8'h00, 64'd0);
        wait_idle();
        send_lit(8'hFF, 64'd2040);
        wait_idle();

        words = '{8'h5A, 8'hC3};
        acc_c = '{0, 0};
        wi = 0;
        for (int t = 0; t < 60 && wi < 2; t++) begin
            in_valid = 1'b1;
            in_data  = words[wi];
            if (in_ready === 1'b1) begin
                push_frame(frame_of(int'(words[wi])), cyc);
                acc_c[wi] = cyc;
                wi++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (wi != 2 || acc_c[1] - acc_c[0] != L + 1) begin
            errors++;
            $display("FAIL back_to_back got accepted=%0d spacing=%0d, want 2 and %0d", wi, acc_c[1] - acc_c[0], L + 1);
        end
        wait_idle();

        send_lit(8'h3C, frame_of(32'h3C));
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            if (x_valid === 1'b1 && sof === 1'b1) found = 1'b1;
            else tick();
        end
        repeat (4) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (!found || x_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort got sof_seen=%0b x_valid=%0b busy=%0b in_ready=%0b, want 1 0 0 1",
                     found, x_valid, busy, in_ready);
        end
        rst = 1'b1;
        send_lit(8'h07, 64'd60);
        wait_idle();

        idx = 0;
        for (int t = 0; t < 20000 && idx < 256; t++) begin
            v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (in_ready === 1'b1) in_data = 8'(idx);
            else in_data = 8'($urandom);
            if (v && in_ready === 1'b1) begin
                push_frame(frame_of(idx), cyc);
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 256) begin
            errors++;
            $display("FAIL sweep_count got %0d frames, want 256", idx);
        end
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
